// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, RGB field positions and a
// shift-add constant multiplier used for image row addressing.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam int RGB_R_MSB = 23;
  localparam int RGB_R_LSB = 16;
  localparam int RGB_G_MSB = 15;
  localparam int RGB_G_LSB = 8;
  localparam int RGB_B_MSB = 7;
  localparam int RGB_B_LSB = 0;

  // Multiply by a constant as a sum of shifted copies; for k=80 this is
  // (x<<6)+(x<<4), so no multiplier is inferred.
  function automatic logic [31:0] const_mul(input logic [31:0] x, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical pixel counters with combinational
// visible/sync/frame-start decode (stage 0 of the fetch pipeline).
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          visible,
  output logic          hs_n,
  output logic          vs_n,
  output logic          fs
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);

  // The line counter only moves on the last pixel of a line.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    visible = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    hs_n    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_n    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    fs      = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_image_fetch.sv
// Image fetcher: turns raster position into scaled image ROM addresses and
// re-aligns sync/blanking with the 1-cycle ROM read before the output pins.
module vga_image_fetch
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter int SCALE_SHIFT = 3,
  parameter int IMG_W       = H_VISIBLE >> SCALE_SHIFT,
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int HW = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP);

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic                  visible, hs_n, vs_n, fs;
  logic [31:0]           row_base, col;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  vis_d1, hs_d1, vs_d1, fs_d1;
  logic                  vis_d2, hs_d2, vs_d2, fs_d2;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .visible (visible),
    .hs_n    (hs_n),
    .vs_n    (vs_n),
    .fs      (fs)
  );

  // Each image word covers a (1<<SCALE_SHIFT)-square block of screen pixels.
  assign row_base  = const_mul(32'(v_cnt >> SCALE_SHIFT), IMG_W);
  assign col       = 32'(h_cnt >> SCALE_SHIFT);
  assign addr_next = visible ? ADDR_WIDTH'(row_base + col) : '0;

  // Flags travel one register per stage so they meet the ROM data at stage 3;
  // reset clears every stage so no stale pixel or partial sync leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= '0;
      vis_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      fs_d1       <= 1'b0;
      vis_d2      <= 1'b0;
      hs_d2       <= 1'b1;
      vs_d2       <= 1'b1;
      fs_d2       <= 1'b0;
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rom_addr    <= addr_next;
      vis_d1      <= visible;
      hs_d1       <= hs_n;
      vs_d1       <= vs_n;
      fs_d1       <= fs;
      vis_d2      <= vis_d1;
      hs_d2       <= hs_d1;
      vs_d2       <= vs_d1;
      fs_d2       <= fs_d1;
      rgb         <= vis_d2 ? rom_rdata : '0;
      hsync       <= hs_d2;
      vsync       <= vs_d2;
      frame_start <= fs_d2;
    end
  end

endmodule

// File: tb/tb_vga_image_fetch.sv
// Bench for vga_image_fetch: a full-size instance and a reduced-timing
// instance, each on a registered ROM model, with scoreboard and directed checks.
module tb_vga_image_fetch;

  localparam logic [26:0] IDLE = {1'b0, 1'b1, 1'b1, 24'h0};

  logic        clk;
  logic        rst;
  logic [12:0] rom_addr_a, rom_addr_b;
  logic [23:0] rom_rdata_a, rom_rdata_b;
  logic [23:0] rgb_a, rgb_b;
  logic        hsync_a, vsync_a, frame_start_a;
  logic        hsync_b, vsync_b, frame_start_b;

  logic [23:0] rom_a [8192];
  logic [23:0] rom_b [8192];

  int cyc      = 0;
  int n_pass   = 0;
  int n_checks = 0;
  int rel;

  logic [26:0] exp_qa[$];
  logic [26:0] exp_qb[$];
  int mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;

  int   fs_a_t[$], hs_fall_a[$], hs_rise_a[$];
  int   fs_b_t[$], vs_fall_b[$], vs_rise_b[$];
  logic prev_hs_a = 1'b1;
  logic prev_vs_b = 1'b1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and ROM models ----------------
  vga_image_fetch dut_a (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr_a),
    .rom_rdata   (rom_rdata_a),
    .rgb         (rgb_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .frame_start (frame_start_a)
  );

  // Reduced raster (48x30 total, 32x24 visible, 4x scale, 8x6 image) so
  // whole frames fit in a short run.
  vga_image_fetch #(
    .H_VISIBLE (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_VISIBLE (24), .V_FP (2), .V_SYNC (2), .V_BP (2),
    .SCALE_SHIFT (2), .IMG_W (8), .ADDR_WIDTH (13), .DATA_WIDTH (24)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr_b),
    .rom_rdata   (rom_rdata_b),
    .rgb         (rgb_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .frame_start (frame_start_b)
  );

  always @(posedge clk) begin
    rom_rdata_a <= rom_a[rom_addr_a];
    rom_rdata_b <= rom_b[rom_addr_b];
  end

  // ---------------- check / model helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [26:0] model_px(input int h, input int v, input int hvis, input int vvis,
                                           input int hs0, input int hs1, input int vs0, input int vs1,
                                           input logic [23:0] word);
    logic vis;
    vis = (h < hvis) && (v < vvis);
    return {(h == 0 && v == 0), !(v >= vs0 && v < vs1), !(h >= hs0 && h < hs1), vis ? word : 24'h0};
  endfunction

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // ---------------- scoreboard: expected queue fed per raster position ----------------
  always @(posedge clk) begin
    if (rst) begin
      exp_qa.delete();
      exp_qb.delete();
      repeat (3) begin
        exp_qa.push_back(IDLE);
        exp_qb.push_back(IDLE);
      end
      mh_a <= 0; mv_a <= 0;
      mh_b <= 0; mv_b <= 0;
    end else begin
      exp_qa.push_back(model_px(mh_a, mv_a, 640, 480, 656, 752, 490, 492,
                                rom_a[13'((mv_a / 8) * 80 + (mh_a / 8))]));
      exp_qb.push_back(model_px(mh_b, mv_b, 32, 24, 36, 44, 26, 28,
                                rom_b[13'((mv_b / 4) * 8 + (mh_b / 4))]));
      if (mh_a == 799) begin
        mh_a <= 0;
        mv_a <= (mv_a == 524) ? 0 : mv_a + 1;
      end else begin
        mh_a <= mh_a + 1;
      end
      if (mh_b == 47) begin
        mh_b <= 0;
        mv_b <= (mv_b == 29) ? 0 : mv_b + 1;
      end else begin
        mh_b <= mh_b + 1;
      end
    end
  end

  // Monitor: the output after each edge answers the entry pushed two edges earlier.
  always @(negedge clk) begin
    if (exp_qa.size() > 2)
      check("a_pixel", 32'({frame_start_a, vsync_a, hsync_a, rgb_a}), 32'(exp_qa.pop_front()));
    if (exp_qb.size() > 2)
      check("b_pixel", 32'({frame_start_b, vsync_b, hsync_b, rgb_b}), 32'(exp_qb.pop_front()));
  end

  // Event timestamps for interval measurements.
  always @(negedge clk) begin
    if (frame_start_a) fs_a_t.push_back(cyc);
    if (prev_hs_a && !hsync_a) hs_fall_a.push_back(cyc);
    if (!prev_hs_a && hsync_a) hs_rise_a.push_back(cyc);
    prev_hs_a <= hsync_a;
    if (frame_start_b) fs_b_t.push_back(cyc);
    if (prev_vs_b && !vsync_b) vs_fall_b.push_back(cyc);
    if (!prev_vs_b && vsync_b) vs_rise_b.push_back(cyc);
    prev_vs_b <= vsync_b;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_events();
    fs_a_t.delete(); hs_fall_a.delete(); hs_rise_a.delete();
    fs_b_t.delete(); vs_fall_b.delete(); vs_rise_b.delete();
  endtask

  task automatic do_reset(input int n, input bit fill_ones, output int rel_cyc);
    @(negedge clk);
    rst = 1'b1;
    if (fill_ones) begin
      for (int i = 0; i < 8192; i++) begin
        rom_a[i] = 24'hFFFFFF;
        rom_b[i] = 24'hFFFFFF;
      end
    end
    repeat (n) @(negedge clk);
    rst = 1'b0;
    clear_events();
    rel_cyc = cyc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      rom_a[i] = 24'(i);
      rom_b[i] = 24'(i);
    end
    @(negedge clk);
    check("rst_rgb", rgb_a, 0);
    check("rst_hsync", hsync_a, 1);
    check("rst_vsync", vsync_a, 1);
    check("rst_rom_addr", rom_addr_a, 0);
    check("rst_frame_start", frame_start_a, 0);

    // Release and run uninterrupted: first frame of dut_a, two+ frames of dut_b.
    do_reset(5, 1'b0, rel);
    wait_until(rel + 3);
    check("a_first_fs", frame_start_a, 1);
    check("a_first_rgb", rgb_a, rom_a[0]);
    wait_until(rel + 1136);
    check("b_last_addr", rom_addr_b, 47);
    wait_until(rel + 1138);
    check("b_last_rgb", rgb_b, 47);
    for (int h = 8; h < 16; h++) begin
      wait_until(rel + 6400 + h + 3);
      check("a_line8_px", rgb_a, 81);
    end
    wait_until(rel + 7000);
    check("a_fs_count", fs_a_t.size(), 1);
    if (fs_a_t.size() > 0) check("a_fs_latency", fs_a_t[0] - rel, 3);
    check("a_hs_fall_count", hs_fall_a.size(), 8);
    if (hs_fall_a.size() >= 2 && hs_rise_a.size() >= 1) begin
      check("a_hs_fall_at", hs_fall_a[0] - rel, 659);
      check("a_hs_width", hs_rise_a[0] - hs_fall_a[0], 96);
      check("a_hs_period", hs_fall_a[1] - hs_fall_a[0], 800);
    end
    check("b_fs_count", fs_b_t.size(), 5);
    if (fs_b_t.size() >= 3) begin
      check("b_fs_latency", fs_b_t[0] - rel, 3);
      check("b_frame_period0", fs_b_t[1] - fs_b_t[0], 1440);
      check("b_frame_period1", fs_b_t[2] - fs_b_t[1], 1440);
    end
    if (vs_fall_b.size() >= 1 && vs_rise_b.size() >= 1) begin
      check("b_vs_fall_at", vs_fall_b[0] - rel, 1251);
      check("b_vs_width", vs_rise_b[0] - vs_fall_b[0], 96);
    end
    check("b_vs_fall_count", vs_fall_b.size(), 4);

    // One-cycle reset while hsync is low on line 2.
    do_reset(5, 1'b0, rel);
    wait_until(rel + 1600 + 700);
    check("a_hs_low_v2", hsync_a, 0);
    rst = 1'b1;
    @(negedge clk);
    check("a_hs_rst_recover", hsync_a, 1);
    rst = 1'b0;
    fs_a_t.delete();
    hs_fall_a.delete();
    rel = cyc;
    wait_until(rel + 1000);
    check("a_fs_after_rst_count", fs_a_t.size(), 1);
    if (fs_a_t.size() > 0) check("a_fs_after_rst", fs_a_t[0] - rel, 3);
    check("a_hs_falls_after_rst", hs_fall_a.size(), 1);
    if (hs_fall_a.size() > 0) check("a_hs_fall_after_rst", hs_fall_a[0] - rel, 659);

    // All-ones ROM: blanking must still force black.
    do_reset(5, 1'b1, rel);
    wait_until(rel + 3);
    check("c_first_rgb", rgb_a, 24'hFFFFFF);
    wait_until(rel + 642);
    check("c_a_h639", rgb_a, 24'hFFFFFF);
    wait_until(rel + 643);
    check("c_a_h640", rgb_a, 0);
    wait_until(rel + 1155);
    check("c_b_vblank", rgb_b, 0);
    wait_until(rel + 1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
